// File: rtl/ram_ctrl.sv
// ram_ctrl: byte-addressable RAM behind a valid/ready request/response handshake.
// Each access runs IDLE -> WAIT (LATENCY cycles, skipped when 0) -> ACCESS -> RESP.
// Optional feature macro: RAM_CTRL_MISALIGN_TRAP_EN faults accesses whose address
// is not a multiple of the access size (default build performs them byte-wise).
module ram_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter int unsigned LATENCY     = 1
) (
    input  logic              clk_mem,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        mem_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       data_i,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       data_o,
    output logic              err
);

    localparam int unsigned     IDX_W   = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t state, state_nx;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [3:0]        cnt;
    logic [63:0]       raw_q;
    logic              bad_q;

    logic [7:0]        mem [DEPTH_BYTES];

    logic [7:0]        bmask;
    logic [2:0]        last_off;
    logic [ADDR_W:0]   end_addr;
    logic              oob;
    logic              mis;
    logic              bad;
    logic [63:0]       rd_bytes;
    logic [63:0]       load_ext;

    // Byte lanes touched by the latched request and its error classification.
    always_comb begin
        bmask    = 8'h01;
        last_off = 3'd0;
        case (size_q)
            2'd0:    begin bmask = 8'h01; last_off = 3'd0; end
            2'd1:    begin bmask = 8'h03; last_off = 3'd1; end
            2'd2:    begin bmask = 8'h0F; last_off = 3'd3; end
            default: begin bmask = 8'hFF; last_off = 3'd7; end
        endcase
        // One extra bit so the last byte address never wraps back into range.
        end_addr = {1'b0, addr_q} + (ADDR_W+1)'(last_off);
        oob      = (end_addr >= DEPTH_L);
`ifdef RAM_CTRL_MISALIGN_TRAP_EN
        mis      = ((addr_q[2:0] & last_off) != 3'd0);
`else
        mis      = 1'b0;
`endif
        bad      = oob | mis;
    end

    // Gather the addressed bytes little-endian; unused upper lanes read as zero.
    always_comb begin
        rd_bytes = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bmask[i]) begin
                rd_bytes[8*i +: 8] = mem[IDX_W'(addr_q + ADDR_W'(i))];
            end
        end
    end

    // Sign- or zero-extend the registered load bytes to 64 bits.
    always_comb begin
        load_ext = raw_q;
        case (size_q)
            2'd0:    load_ext = {{56{~uns_q & raw_q[7]}},  raw_q[7:0]};
            2'd1:    load_ext = {{48{~uns_q & raw_q[15]}}, raw_q[15:0]};
            2'd2:    load_ext = {{32{~uns_q & raw_q[31]}}, raw_q[31:0]};
            default: load_ext = raw_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and request handshake.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = (LATENCY == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT:   if (cnt <= 4'd1) state_nx = S_ACCESS;
            S_ACCESS: state_nx = S_RESP;
            S_RESP:   if (rsp_valid && rsp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Request latch, wait counter, load capture and response registers.
    // RESP spends its first cycle formatting data_o from the bytes captured on
    // the ACCESS exit edge, so rsp_valid rises LATENCY+2 edges after acceptance.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            raw_q     <= '0;
            bad_q     <= 1'b0;
            rsp_valid <= 1'b0;
            data_o    <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= mem_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= addr;
                        wdata_q <= data_i;
                        cnt     <= 4'(LATENCY);
                    end
                end
                S_WAIT: cnt <= cnt - 4'd1;
                S_ACCESS: begin
                    raw_q <= rd_bytes;
                    bad_q <= bad;
                end
                S_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        err       <= bad_q;
                        data_o    <= (bad_q || we_q) ? '0 : load_ext;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        err       <= 1'b0;
                        data_o    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Store commit on the ACCESS exit edge; storage is deliberately not reset.
    always_ff @(posedge clk_mem) begin
        if (state == S_ACCESS && we_q && !bad) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (bmask[i]) begin
                    mem[IDX_W'(addr_q + ADDR_W'(i))] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: scoreboard bench for ram_ctrl. A driver issues directed and
// random requests, a byte-array reference model predicts each response, and a
// monitor checks every response (value, error flag, latency, hold stability).
module tb_ram_ctrl;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned LAT   = 1;

    logic          clk_mem      = 1'b0;
    logic          reset        = 1'b0;
    logic          req_valid    = 1'b0;
    logic          req_ready;
    logic          req_we       = 1'b0;
    logic [1:0]    mem_size     = '0;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] addr         = '0;
    logic [63:0]   data_i       = '0;
    logic          rsp_valid;
    logic          rsp_ready    = 1'b0;
    logic [63:0]   data_o;
    logic          err;

    always #5 clk_mem = ~clk_mem;

    ram_ctrl #(.ADDR_W(AW), .DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk_mem      (clk_mem),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .mem_size     (mem_size),
        .req_unsigned (req_unsigned),
        .addr         (addr),
        .data_i       (data_i),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .data_o       (data_o),
        .err          (err)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int unsigned acc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [7:0]  ref_mem [DEPTH];

    always @(posedge clk_mem) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference model: byte array, bounds/alignment rules, arithmetic extension.
    function automatic void ref_access(input bit we, input logic [1:0] size, input bit uns,
                                       input longint unsigned a, input logic [63:0] wd,
                                       output logic [63:0] d, output logic e);
        int unsigned n = 1 << size;
        logic [63:0] v = '0;
        e = (a + n - 1 >= DEPTH);
`ifdef RAM_CTRL_MISALIGN_TRAP_EN
        if (a % n != 0) e = 1'b1;
`endif
        d = '0;
        if (e) return;
        for (int unsigned i = 0; i < n; i++) begin
            if (we) ref_mem[a + i] = wd[8*i +: 8];
            else    v[8*i +: 8] = ref_mem[a + i];
        end
        if (!we) begin
            if (size != 2'd3 && !uns) d = $signed(v << (64 - 8*n)) >>> (64 - 8*n);
            else                      d = v;
        end
    endfunction

    task automatic tick();
        @(posedge clk_mem);
        #1;
    endtask

    task automatic junk();
        req_valid    = 1'($urandom_range(0, 1));
        req_we       = 1'($urandom_range(0, 1));
        mem_size     = 2'($urandom);
        req_unsigned = 1'($urandom_range(0, 1));
        addr         = $urandom;
        data_i       = {$urandom, $urandom};
    endtask

    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [AW-1:0] a, input logic [63:0] wd,
                          input int unsigned hold, input string tag,
                          input bit use_k, input logic [63:0] kd, input logic ke);
        exp_t        x;
        int unsigned n;
        ref_access(we, size, uns, {32'd0, a}, wd, x.data, x.err);
        if (use_k) begin
            x.data = kd;
            x.err  = ke;
        end
        req_valid = 1'b1; req_we = we; mem_size = size; req_unsigned = uns;
        addr = a; data_i = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
        if (req_ready !== 1'b1) begin
            check({tag, " accept timeout"}, 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        tick();
        x.acc = cyc;
        x.tag = tag;
        sb.push_back(x);
        req_valid = 1'b0;
        check({tag, " busy req_ready"}, req_ready, 1'b0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            junk();
            tick();
            n++;
            check({tag, " ignore req_ready"}, req_ready, 1'b0);
        end
        req_valid = 1'b0;
        if (rsp_valid !== 1'b1) begin
            check({tag, " rsp timeout"}, 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_back());
            return;
        end
        for (int unsigned h = 0; h < hold; h++) begin
            junk();
            tick();
            check({tag, " held req_ready"}, req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " idle req_ready"}, req_ready, 1'b1);
    endtask

    // Monitor: pop on each new response, then hold the popped value while it stays up.
    logic prev_v = 1'b0;
    exp_t cur;
    always @(negedge clk_mem) begin
        if (rsp_valid === 1'b1 && prev_v !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected response", 64'd1, 64'd0);
            end else begin
                cur = sb.pop_front();
                check({cur.tag, " data"}, data_o, cur.data);
                check({cur.tag, " err"}, err, cur.err);
                check({cur.tag, " latency"}, 64'(cyc - cur.acc), 64'(2 + LAT));
            end
        end else if (rsp_valid === 1'b1) begin
            check({cur.tag, " hold data"}, data_o, cur.data);
            check({cur.tag, " hold err"}, err, cur.err);
        end
        prev_v = rsp_valid;
    end

    initial begin
        int unsigned r;
        logic [AW-1:0] a;

        #1 reset = 1'b1;
        #2;
        check("reset req_ready", req_ready, 1'b1);
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset data_o", data_o, 64'd0);
        check("reset err", err, 1'b0);
        #10 reset = 1'b0;
        tick();

        for (int unsigned fa = 0; fa < 32'h400; fa += 8)
            do_req(1'b1, 2'd3, 1'b0, fa, {$urandom, $urandom}, 0, "fill", 1'b0, '0, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 32'hFF0, {$urandom, $urandom}, 0, "fill top", 1'b0, '0, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 32'hFF8, 64'h0123456789ABCDEF, 0, "fill ff8", 1'b1, 64'd0, 1'b0);

        do_req(1'b1, 2'd3, 1'b0, 32'h10, 64'h8877665544332211, 0, "st dw 10", 1'b1, 64'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h14, '0, 0, "ld w 14 signed", 1'b1, 64'hFFFFFFFF88776655, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h10, '0, 0, "ld b 10 unsigned", 1'b1, 64'h11, 1'b0);

        do_req(1'b1, 2'd2, 1'b0, 32'hFFE, 64'hDEADBEEF, 0, "st w ffe oob", 1'b1, 64'd0, 1'b1);
        do_req(1'b0, 2'd1, 1'b1, 32'hFFE, '0, 0, "ld h ffe", 1'b1, 64'h0123, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, '0, 0, "ld b top addr", 1'b1, 64'd0, 1'b1);

`ifdef RAM_CTRL_MISALIGN_TRAP_EN
        do_req(1'b1, 2'd1, 1'b0, 32'h21, 64'hBEEF, 0, "st h 21 trap", 1'b1, 64'd0, 1'b1);
        do_req(1'b0, 2'd1, 1'b0, 32'h21, '0, 0, "ld h 21 trap", 1'b1, 64'd0, 1'b1);
        do_req(1'b0, 2'd0, 1'b1, 32'h21, '0, 0, "ld b 21", 1'b0, '0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h22, '0, 0, "ld b 22", 1'b0, '0, 1'b0);
`else
        do_req(1'b1, 2'd1, 1'b0, 32'h21, 64'hBEEF, 0, "st h 21", 1'b1, 64'd0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h21, '0, 0, "ld h 21", 1'b1, 64'hFFFFFFFFFFFFBEEF, 1'b0);
`endif

        do_req(1'b0, 2'd3, 1'b0, 32'h10, '0, 5, "hold 5", 1'b1, 64'h8877665544332211, 1'b0);

        do_req(1'b1, 2'd0, 1'b0, 32'h30, 64'h55, 0, "st b 30", 1'b1, 64'd0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; mem_size = 2'd0; req_unsigned = 1'b0;
        addr = 32'h30; data_i = 64'hAA;
        check("pre-reset accept req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check("wait req_ready", req_ready, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("mid reset req_ready", req_ready, 1'b1);
        check("mid reset rsp_valid", rsp_valid, 1'b0);
        check("mid reset data_o", data_o, 64'd0);
        check("mid reset err", err, 1'b0);
        #2 reset = 1'b0;
        tick();
        do_req(1'b0, 2'd0, 1'b1, 32'h30, '0, 0, "ld b 30 after reset", 1'b1, 64'h55, 1'b0);

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = $urandom_range(0, 32'h3F8);
            else if (r == 8) a = 32'hFF0 + $urandom_range(0, 15);
            else             a = $urandom;
            do_req(1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 1)), a,
                   {$urandom, $urandom}, $urandom_range(0, 3), "random", 1'b0, '0, 1'b0);
        end

        repeat (5) tick();
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning request address width in bits.
REQ-002 SHALL have parameter DEPTH_BYTES, default 4096, meaning byte-addressable storage size; legal range 8..2^ADDR_W.
REQ-003 SHALL have parameter LATENCY, default 1, meaning extra wait cycles per access; legal range 0..15.
REQ-004 SHALL have port clk_mem, input, 1, meaning single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, meaning request present.
REQ-007 SHALL have port req_ready, output, 1, meaning controller can accept a request.
REQ-008 SHALL have port req_we, input, 1, meaning 1 = store, 0 = load.
REQ-009 SHALL have port mem_size, input, 2, meaning access size: 0 byte, 1 half, 2 word, 3 double.
REQ-010 SHALL have port req_unsigned, input, 1, meaning zero-extend load data instead of sign-extend.
REQ-011 SHALL have port addr, input, ADDR_W, meaning byte address of the lowest byte.
REQ-012 SHALL have port data_i, input, 64, meaning store data, little-endian, low bytes used.
REQ-013 SHALL have port rsp_valid, output, 1, meaning response present.
REQ-014 SHALL have port rsp_ready, input, 1, meaning consumer accepts response.
REQ-015 SHALL have port data_o, output, 64, meaning extended load data; 0 for stores and errors.
REQ-016 SHALL have port err, output, 1, meaning response reports a failed access; qualified by rsp_valid.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT (skipped when LATENCY=0) -> ACCESS -> RESP -> IDLE.
REQ-018 SHALL assert req_ready only in IDLE; acceptance = req_valid & req_ready at a rising edge, latching all request fields.
REQ-019 SHALL count down LATENCY cycles in WAIT with a 4-bit counter, then enter ACCESS.
REQ-020 SHALL perform the access in ACCESS's single cycle; store bytes commit at the edge leaving ACCESS; load data registered at the same edge.
REQ-021 SHALL raise rsp_valid at edge N+2+LATENCY for a request accepted at edge N.
REQ-022 SHALL hold rsp_valid, data_o and err stable in RESP until rsp_ready is high at an edge, then return to IDLE.
REQ-023 SHALL store/load 1, 2, 4 or 8 bytes little-endian at addr..addr+n-1, byte-wise, any alignment.
REQ-024 SHALL sign-extend byte, half and word loads to 64 bits unless req_unsigned=1; SHALL ignore req_unsigned for double.
REQ-025 SHALL flag err=1, suppress any write and return data_o=0 when addr+n-1 >= DEPTH_BYTES; no wrap-around.
REQ-026 SHALL ignore req_valid outside IDLE; requests are never queued.

Reset
REQ-027 SHALL on reset, immediately and regardless of clock: state IDLE, req_ready=1, rsp_valid=0, data_o=0, err=0, counter=0.
REQ-028 SHALL drop an accepted, uncommitted store when reset asserts before the ACCESS-exit edge; memory contents are never cleared by reset.

Configuration
REQ-029 SHALL, with RAM_CTRL_MISALIGN_TRAP_EN defined, treat any access with addr not a multiple of its size as an error: err=1, data_o=0, no write.
REQ-030 SHALL, without RAM_CTRL_MISALIGN_TRAP_EN, perform misaligned accesses byte-wise per REQ-023 with err=0.

Verification
REQ-031 SHALL cover: LATENCY=1, store double 0x8877665544332211 @0x10, then load word @0x14 signed -> data_o=0xFFFFFFFF88776655, err=0.
REQ-032 SHALL cover: load byte @0x10 with req_unsigned=1 after REQ-031 -> data_o=0x11; accept at edge N -> rsp_valid at edge N+3.
REQ-033 SHALL cover: DEPTH_BYTES=4096, store word @0xFFE -> err=1, bytes 0xFFE/0xFFF unchanged on reload.
REQ-034 SHALL cover: store half 0xBEEF @0x21 with and without RAM_CTRL_MISALIGN_TRAP_EN -> err=1/no write vs. err=0 and load half @0x21 = 0xFFFFFFFFFFFFBEEF.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid, data_o stable, req_ready=0; second req_valid ignored.
REQ-036 SHALL cover: reset pulse during WAIT of a store 0xAA @0x30 -> outputs at reset values immediately, byte @0x30 unchanged.
